// File: rtl/ppu_bg_pipe.sv
// PPU background pipeline: dot/line counters, NT/AT/PT fetch, shifters,
// fine-X select, left clip, palette lookup, one vbuf write per visible dot.
// Ports:
//   i_clk, i_rst         clock, async active-high reset
//   i_ppuctrl/mask       [4]=pt sel,[1:0]=nt base / [3]=bg en,[1]=left8,[0]=gray
//   i_ppuscrollX/Y       {coarse[4:0], fine[2:0]}
//   i_vblank             vblank level; a rising edge starts a frame
//   o_nt_addr/i_nt_rdata nametable/attribute read, 1-cycle latency
//   o_pt_addr/i_pt_rdata pattern read {hi,lo}, 1-cycle latency
//   o_plt_addr/i_plt_rdata palette read, 1-cycle latency
//   o_vbuf_*             pixel write, addr = y*256+x
// Macro PPU_BG_GRAY_EN: when defined, mask[0] masks pixel colour with 0x30.
module ppu_bg_pipe #(
    parameter int SCAN_X_MAX = 339,
    parameter int PRE_LINE   = 261,
    parameter int VIS_H      = 240,
    parameter int VBUF_AW    = 17
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [5:0]         i_ppuctrl,
    input  logic [7:0]         i_ppumask,
    input  logic [7:0]         i_ppuscrollX,
    input  logic [7:0]         i_ppuscrollY,
    input  logic               i_vblank,
    output logic [11:0]        o_nt_addr,
    input  logic [7:0]         i_nt_rdata,
    output logic [11:0]        o_pt_addr,
    input  logic [15:0]        i_pt_rdata,
    output logic [4:0]         o_plt_addr,
    input  logic [7:0]         i_plt_rdata,
    output logic [VBUF_AW-1:0] o_vbuf_addr,
    output logic               o_vbuf_we,
    output logic [7:0]         o_vbuf_wdata
);

    localparam logic [8:0] X_MAX  = 9'(SCAN_X_MAX);
    localparam logic [8:0] Y_PRE  = 9'(PRE_LINE);
    localparam logic [8:0] Y_VIS  = 9'(VIS_H);
    localparam logic [8:0] Y_LAST = 9'(VIS_H - 1);

    logic [2:0]         vb_q;
    logic               vb_rise;
    logic               run;
    logic [8:0]         x;
    logic [8:0]         y;
    logic [2:0]         p;
    logic [4:0]         nt_x;
    logic [4:0]         nt_y;
    logic [2:0]         fine_x;
    logic [2:0]         fine_y;
    logic [1:0]         nt_base;
    logic [7:0]         tile;
    logic [1:0]         attr;
    logic [1:0]         attr_sel;
    logic [15:0]        pt_lat;
    logic [15:0]        sh_ph;
    logic [15:0]        sh_pl;
    logic [15:0]        sh_ah;
    logic [15:0]        sh_al;
    logic               render_line;
    logic               fetch_win;
    logic               fetch_act;
    logic               pix_act;
    logic [3:0]         bit_sel;
    logic [3:0]         pix;
    logic [4:0]         plt_nxt;
    logic [VBUF_AW-1:0] addr_cur;
    logic [VBUF_AW-1:0] a1;
    logic [VBUF_AW-1:0] a2;
    logic               v1;
    logic               v2;
    logic [7:0]         pix_data;
    logic               unused;

    assign unused = ^{i_ppuctrl[5], i_ppuctrl[3:2],
                      i_ppumask[7:4], i_ppumask[2], i_ppumask[0]};

    // vb_q[1] is the twice-registered level; vb_q[2] its previous value
    assign vb_rise     = vb_q[1] & ~vb_q[2];
    assign p           = x[2:0];
    assign render_line = run && (y < Y_VIS || y == Y_PRE);
    assign fetch_win   = (x < 9'd256) || (x >= 9'd320 && x <= 9'd335);
    assign fetch_act   = render_line && i_ppumask[3] && fetch_win;
    assign pix_act     = run && (y < Y_VIS) && (x < 9'd256);
    assign addr_cur    = VBUF_AW'({y[7:0], x[7:0]});

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            vb_q <= '0;
            run  <= 1'b0;
            x    <= '0;
            y    <= '0;
        end else begin
            vb_q <= {vb_q[1:0], i_vblank};
            if (vb_rise) begin
                run <= 1'b1;
                x   <= '0;
                y   <= Y_VIS;
            end else if (run) begin
                if (x == X_MAX) begin
                    if (y == Y_LAST) begin
                        run <= 1'b0;
                    end else begin
                        x <= '0;
                        y <= (y == Y_PRE) ? '0 : y + 9'd1;
                    end
                end else begin
                    x <= x + 9'd1;
                end
            end
        end
    end

    // Scroll position: coarse/fine counters and nametable select bits
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            nt_x    <= '0;
            nt_y    <= '0;
            fine_x  <= '0;
            fine_y  <= '0;
            nt_base <= '0;
        end else if (render_line) begin
            if (fetch_act && p == 3'd7) begin
                nt_x <= nt_x + 5'd1;
                if (nt_x == 5'd31) nt_base[0] <= ~nt_base[0];
            end
            if (x == 9'd256) begin
                fine_y <= fine_y + 3'd1;
                if (fine_y == 3'd7) begin
                    // rows 30/31 hold attribute data: 31 wraps, no toggle
                    if (nt_y == 5'd29) begin
                        nt_y       <= '0;
                        nt_base[1] <= ~nt_base[1];
                    end else begin
                        nt_y <= nt_y + 5'd1;
                    end
                end
            end
            if (x == 9'd257) begin
                nt_x       <= i_ppuscrollX[7:3];
                fine_x     <= i_ppuscrollX[2:0];
                nt_base[0] <= i_ppuctrl[0];
            end
            if (x == 9'd304 && y == Y_PRE) begin
                nt_y       <= i_ppuscrollY[7:3];
                fine_y     <= i_ppuscrollY[2:0];
                nt_base[1] <= i_ppuctrl[1];
            end
        end
    end

    always_comb begin
        attr_sel = i_nt_rdata[1:0];
        unique case ({nt_y[1], nt_x[1]})
            2'b00: attr_sel = i_nt_rdata[1:0];
            2'b01: attr_sel = i_nt_rdata[3:2];
            2'b10: attr_sel = i_nt_rdata[5:4];
            2'b11: attr_sel = i_nt_rdata[7:6];
        endcase
    end

    always_comb begin
        o_nt_addr = '0;
        o_pt_addr = '0;
        if (fetch_act) begin
            if (p == 3'd0) o_nt_addr = {nt_base, nt_y, nt_x};
            if (p == 3'd2) o_nt_addr = {nt_base, 4'hF, nt_y[4:2], nt_x[4:2]};
            if (p == 3'd4) o_pt_addr = {i_ppuctrl[4], tile, fine_y};
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            tile   <= '0;
            attr   <= '0;
            pt_lat <= '0;
            sh_ph  <= '0;
            sh_pl  <= '0;
            sh_ah  <= '0;
            sh_al  <= '0;
        end else if (fetch_act) begin
            if (p == 3'd1) tile   <= i_nt_rdata;
            if (p == 3'd3) attr   <= attr_sel;
            if (p == 3'd5) pt_lat <= i_pt_rdata;
            // p7: shift once and refill the low byte with the new tile
            if (p == 3'd7) begin
                sh_ph <= {sh_ph[14:7], pt_lat[15:8]};
                sh_pl <= {sh_pl[14:7], pt_lat[7:0]};
                sh_ah <= {sh_ah[14:7], {8{attr[1]}}};
                sh_al <= {sh_al[14:7], {8{attr[0]}}};
            end else begin
                sh_ph <= {sh_ph[14:0], 1'b0};
                sh_pl <= {sh_pl[14:0], 1'b0};
                sh_ah <= {sh_ah[14:0], 1'b0};
                sh_al <= {sh_al[14:0], 1'b0};
            end
        end
    end

    always_comb begin
        bit_sel = 4'd15 - {1'b0, fine_x};
        pix     = {sh_ah[bit_sel], sh_al[bit_sel],
                   sh_ph[bit_sel], sh_pl[bit_sel]};
        plt_nxt = {1'b0, pix};
        if (pix[1:0] == 2'b00 || !i_ppumask[3] ||
            (x < 9'd8 && !i_ppumask[1])) begin
            plt_nxt = '0;
        end
    end

`ifdef PPU_BG_GRAY_EN
    assign pix_data = i_ppumask[0] ? (i_plt_rdata & 8'h30) : i_plt_rdata;
`else
    assign pix_data = i_plt_rdata;
`endif

    // dot d: palette addr at d+1, palette data at d+2, vbuf write at d+3
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_plt_addr   <= '0;
            v1           <= 1'b0;
            v2           <= 1'b0;
            a1           <= '0;
            a2           <= '0;
            o_vbuf_we    <= 1'b0;
            o_vbuf_addr  <= '0;
            o_vbuf_wdata <= '0;
        end else begin
            o_plt_addr <= pix_act ? plt_nxt : '0;
            v1         <= pix_act;
            a1         <= addr_cur;
            v2         <= v1;
            a2         <= a1;
            o_vbuf_we  <= v2;
            if (v2) begin
                o_vbuf_addr  <= a2;
                o_vbuf_wdata <= pix_data;
            end
        end
    end

endmodule

// File: tb/tb_ppu_bg_pipe.sv
// Bench for ppu_bg_pipe with a reduced frame (8 visible lines).
// Pixels are predicted from scroll arithmetic over bench-side memories.
module tb_ppu_bg_pipe;

    localparam int VIS   = 8;
    localparam int PRE   = 10;
    localparam int NPIX  = VIS * 256;
    localparam int FRAME = (PRE + 1) * 340;
    localparam int PRE_D = (PRE - VIS) * 340;
    localparam int L0_D  = PRE_D + 340;

    logic        clk;
    logic        i_rst;
    logic [5:0]  i_ppuctrl;
    logic [7:0]  i_ppumask;
    logic [7:0]  i_ppuscrollX;
    logic [7:0]  i_ppuscrollY;
    logic        i_vblank;
    logic [11:0] o_nt_addr;
    logic [7:0]  nt_rdata;
    logic [11:0] o_pt_addr;
    logic [15:0] pt_rdata;
    logic [4:0]  o_plt_addr;
    logic [7:0]  plt_rdata;
    logic [16:0] o_vbuf_addr;
    logic        o_vbuf_we;
    logic [7:0]  o_vbuf_wdata;

    logic [7:0]  ntmem [4096];
    logic [15:0] ptmem [4096];
    logic [7:0]  pal   [32];
    logic [7:0]  expv  [NPIX];

    int checks;
    int errors;

    ppu_bg_pipe #(
        .SCAN_X_MAX(339),
        .PRE_LINE  (PRE),
        .VIS_H     (VIS),
        .VBUF_AW   (17)
    ) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_ppuctrl   (i_ppuctrl),
        .i_ppumask   (i_ppumask),
        .i_ppuscrollX(i_ppuscrollX),
        .i_ppuscrollY(i_ppuscrollY),
        .i_vblank    (i_vblank),
        .o_nt_addr   (o_nt_addr),
        .i_nt_rdata  (nt_rdata),
        .o_pt_addr   (o_pt_addr),
        .i_pt_rdata  (pt_rdata),
        .o_plt_addr  (o_plt_addr),
        .i_plt_rdata (plt_rdata),
        .o_vbuf_addr (o_vbuf_addr),
        .o_vbuf_we   (o_vbuf_we),
        .o_vbuf_wdata(o_vbuf_wdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        nt_rdata  <= ntmem[o_nt_addr];
        pt_rdata  <= ptmem[o_pt_addr];
        plt_rdata <= pal[o_plt_addr];
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    // Screen pixel (x,y) sits at world column sx+x; vertical position
    // advances one scanline per line with the 29/31 row wrap rules.
    task automatic build_exp(input logic [7:0] sx, input logic [7:0] sy,
                             input logic [5:0] ct, input logic [7:0] mk);
        int cx, fx, cy, fy, nby;
        cx  = int'(sx[7:3]);
        fx  = int'(sx[2:0]);
        cy  = int'(sy[7:3]);
        fy  = int'(sy[2:0]);
        nby = int'(ct[1]);
        for (int yy = 0; yy < VIS; yy++) begin
            for (int xx = 0; xx < 256; xx++) begin
                int t, col, nbx, b, base, tl, at, pix, pa;
                logic [15:0] pw;
                logic [7:0]  d;
                t    = cx + (fx + xx) / 8;
                col  = t % 32;
                nbx  = int'(ct[0]) ^ ((t >= 32) ? 1 : 0);
                b    = (fx + xx) % 8;
                base = nby * 2048 + nbx * 1024;
                tl   = int'(ntmem[base + cy * 32 + col]);
                at   = int'(ntmem[base + 960 + (cy / 4) * 8 + col / 4]);
                at   = (at >> (((cy / 2) % 2) * 4 + ((col / 2) % 2) * 2)) % 4;
                pw   = ptmem[int'(ct[4]) * 2048 + tl * 8 + fy];
                pix  = at * 4 + int'(pw[15 - b]) * 2 + int'(pw[7 - b]);
                pa   = pix;
                if (pix % 4 == 0 || !mk[3] || (xx < 8 && !mk[1])) pa = 0;
                d = pal[pa];
`ifdef PPU_BG_GRAY_EN
                if (mk[0]) d = d & 8'h30;
`endif
                expv[yy * 256 + xx] = d;
            end
            fy++;
            if (fy == 8) begin
                fy = 0;
                if (cy == 29) begin
                    cy  = 0;
                    nby = nby ^ 1;
                end else begin
                    cy = (cy + 1) % 32;
                end
            end
        end
    endtask

    task automatic run_frame(input string tag, input logic [7:0] sx,
                             input logic [7:0] sy, input logic [5:0] ct,
                             input logic [7:0] mk, input logic chk_nt,
                             input logic [11:0] n0, input logic [11:0] n1,
                             input logic [11:0] n2, input logic want_idle,
                             output logic [7:0] first_wd);
        int k;
        int busy;
        build_exp(sx, sy, ct, mk);
        @(posedge clk);
        #1;
        i_ppuscrollX = sx;
        i_ppuscrollY = sy;
        i_ppuctrl    = ct;
        i_ppumask    = mk;
        i_vblank     = 1'b1;
        repeat (3) @(posedge clk);
        k        = 0;
        busy     = 0;
        first_wd = 8'h00;
        for (int d = 0; d < FRAME + 16; d++) begin
            #1;
            if (d == 20) i_vblank = 1'b0;
            if (chk_nt && d == PRE_D + 320)
                chk({tag, "_nt0"}, 32'(o_nt_addr), 32'(n0));
            if (chk_nt && d == PRE_D + 328)
                chk({tag, "_nt1"}, 32'(o_nt_addr), 32'(n1));
            if (chk_nt && d == L0_D)
                chk({tag, "_nt2"}, 32'(o_nt_addr), 32'(n2));
            if (o_nt_addr != 12'd0 || o_pt_addr != 12'd0) busy++;
            if (o_vbuf_we) begin
                if (k == 0) first_wd = o_vbuf_wdata;
                if (k < NPIX)
                    chk({tag, "_px"}, {7'd0, o_vbuf_addr, o_vbuf_wdata},
                        {7'd0, 17'(k), expv[k]});
                else
                    chk({tag, "_extra"}, 32'(k), 32'(NPIX - 1));
                k++;
            end
            @(posedge clk);
        end
        chk({tag, "_wcnt"}, 32'(k), 32'(NPIX));
        if (want_idle) chk({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        logic [7:0]  wd;
        logic [7:0]  gray_want;
        int          wcount;
        checks       = 0;
        errors       = 0;
        i_rst        = 1'b1;
        i_vblank     = 1'b0;
        i_ppuctrl    = '0;
        i_ppumask    = '0;
        i_ppuscrollX = '0;
        i_ppuscrollY = '0;
        for (int i = 0; i < 4096; i++) begin
            ntmem[i] = 8'($urandom);
            ptmem[i] = 16'($urandom);
        end
        for (int i = 0; i < 32; i++) pal[i] = 8'($urandom);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_addr", {3'd0, o_nt_addr, o_pt_addr, o_plt_addr, o_vbuf_we}, 0);
        chk("rst_vbuf", {7'd0, o_vbuf_addr, o_vbuf_wdata}, 0);
        i_rst = 1'b0;

        run_frame("s00", 8'h00, 8'h00, 6'h00, 8'h0A, 1'b1,
                  12'h000, 12'h001, 12'h002, 1'b0, wd);
        run_frame("sx03", 8'h03, 8'h00, 6'h00, 8'h0A, 1'b0,
                  12'h0, 12'h0, 12'h0, 1'b0, wd);
        run_frame("sxF8", 8'hF8, 8'h00, 6'h00, 8'h0A, 1'b1,
                  12'h01F, 12'h400, 12'h401, 1'b0, wd);
        run_frame("sy_wrap", 8'($urandom), 8'hEE, 6'($urandom), 8'h0A, 1'b0,
                  12'h0, 12'h0, 12'h0, 1'b0, wd);
        run_frame("clip", 8'($urandom), 8'hFD, 6'($urandom), 8'h08, 1'b0,
                  12'h0, 12'h0, 12'h0, 1'b0, wd);
        run_frame("bgoff", 8'($urandom), 8'($urandom), 6'($urandom), 8'h02,
                  1'b0, 12'h0, 12'h0, 12'h0, 1'b1, wd);
        for (int r = 0; r < 3; r++) begin
            run_frame("rnd", 8'($urandom), 8'($urandom), 6'($urandom),
                      (8'($urandom) & 8'h07) | 8'h08, 1'b0,
                      12'h0, 12'h0, 12'h0, 1'b0, wd);
        end

        for (int i = 0; i < 32; i++) pal[i] = 8'h2C;
`ifdef PPU_BG_GRAY_EN
        gray_want = 8'h20;
`else
        gray_want = 8'h2C;
`endif
        run_frame("gray", 8'h00, 8'h00, 6'h00, 8'h0B, 1'b0,
                  12'h0, 12'h0, 12'h0, 1'b0, wd);
        chk("gray_wd", 32'(wd), 32'(gray_want));
        for (int i = 0; i < 32; i++) pal[i] = 8'($urandom);

        // Reset in the middle of visible line 0
        @(posedge clk);
        #1;
        i_ppumask = 8'h0A;
        i_vblank  = 1'b1;
        repeat (3) @(posedge clk);
        for (int d = 0; d < L0_D + 100; d++) begin
            #1;
            if (d == 20) i_vblank = 1'b0;
            @(posedge clk);
        end
        #1;
        i_rst = 1'b1;
        #1;
        chk("mid_rst_addr",
            {3'd0, o_nt_addr, o_pt_addr, o_plt_addr, o_vbuf_we}, 0);
        chk("mid_rst_vbuf", {7'd0, o_vbuf_addr, o_vbuf_wdata}, 0);
        repeat (2) @(posedge clk);
        #1;
        i_rst  = 1'b0;
        wcount = 0;
        for (int c = 0; c < 1000; c++) begin
            @(posedge clk);
            #1;
            if (o_vbuf_we) wcount++;
        end
        chk("post_rst_idle", 32'(wcount), 32'd0);

        run_frame("recover", 8'($urandom), 8'($urandom), 6'($urandom),
                  8'h0A, 1'b0, 12'h0, 12'h0, 12'h0, 1'b0, wd);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
